// File: rtl/pipe_mux_n_to_1.sv
// Registered N:1 channel mux, fixed-select or round-robin; latency 1 cycle.
// Backpressure: output register loads only when empty or drained (ld); otherwise all state holds.
module pipe_mux_n_to_1 #(
  parameter int size     = 32,
  parameter int channels = 4,
  parameter int sel_w    = 2,
  parameter int rr_mode  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [channels*size-1:0] data_i,
  input  logic [channels-1:0]      valid_i,
  output logic [channels-1:0]      ready_o,
  input  logic [sel_w-1:0]         select_i,
  output logic [size-1:0]          data_o,
  output logic                     valid_o,
  output logic [sel_w-1:0]         sel_o,
  input  logic                     ready_i
);

  logic             ld;
  logic             cand_vld;
  logic [sel_w-1:0] cand;
  logic [size-1:0]  cand_dat;
  logic             xfer;
  logic [sel_w-1:0] last_grant;
  int               idx;

  assign ld = !valid_o || ready_i;

  // Candidate selection; round-robin wraps modulo channels, not 2**sel_w.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    idx      = 0;
    if (rr_mode != 0) begin
      for (int i = 1; i <= channels; i++) begin
        idx = int'(last_grant) + i;
        if (idx >= channels) idx = idx - channels;
        if (!cand_vld && valid_i[idx]) begin
          cand_vld = 1'b1;
          cand     = sel_w'(idx);
        end
      end
    end else begin
      cand     = select_i;
      cand_vld = int'(select_i) < channels;
    end
  end

  always_comb begin
    cand_dat = '0;
    ready_o  = '0;
    for (int k = 0; k < channels; k++) begin
      if (cand_vld && k == int'(cand)) begin
        cand_dat   = data_i[k*size +: size];
        ready_o[k] = ld;
      end
    end
  end

  assign xfer = |(ready_o & valid_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      sel_o      <= '0;
      last_grant <= sel_w'(channels - 1);
    end else if (ld) begin
      valid_o <= xfer;
      if (xfer) begin
        data_o <= cand_dat;
        sel_o  <= cand;
        if (rr_mode != 0) last_grant <= cand;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux_n_to_1.sv
// Scoreboarded bench: fixed 4-channel, round-robin 4-channel and fixed 3-channel instances.
module tb_pipe_mux_n_to_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [127:0] a_din;  logic [3:0] a_vin, a_rdy;  logic [1:0] a_sel_in, a_sel_out;
  logic [31:0]  a_dout; logic a_vout, a_cready;
  logic [127:0] b_din;  logic [3:0] b_vin, b_rdy;  logic [1:0] b_sel_in, b_sel_out;
  logic [31:0]  b_dout; logic b_vout, b_cready;
  logic [95:0]  c_din;  logic [2:0] c_vin, c_rdy;  logic [1:0] c_sel_in, c_sel_out;
  logic [31:0]  c_dout; logic c_vout, c_cready;

  pipe_mux_n_to_1 #(.size(32), .channels(4), .sel_w(2), .rr_mode(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .data_i(a_din), .valid_i(a_vin), .ready_o(a_rdy),
    .select_i(a_sel_in), .data_o(a_dout), .valid_o(a_vout), .sel_o(a_sel_out), .ready_i(a_cready));
  pipe_mux_n_to_1 #(.size(32), .channels(4), .sel_w(2), .rr_mode(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .data_i(b_din), .valid_i(b_vin), .ready_o(b_rdy),
    .select_i(b_sel_in), .data_o(b_dout), .valid_o(b_vout), .sel_o(b_sel_out), .ready_i(b_cready));
  pipe_mux_n_to_1 #(.size(32), .channels(3), .sel_w(2), .rr_mode(0)) u_c (
    .clk_i(clk), .rst_i(rst_n), .data_i(c_din), .valid_i(c_vin), .ready_o(c_rdy),
    .select_i(c_sel_in), .data_o(c_dout), .valid_o(c_vout), .sel_o(c_sel_out), .ready_i(c_cready));

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  sel;
  } beat_t;

  beat_t a_q[$], b_q[$], c_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic beat_t mk(input logic [31:0] dat, input logic [1:0] sel);
    beat_t b;
    b.dat = dat;
    b.sel = sel;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted output beat must match the head of its scoreboard queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && a_vout && a_cready) begin
      if (a_q.size() == 0) begin
        total_cnt++;
        $display("FAIL a_extra_beat: got data %0h sel %0d with nothing expected", a_dout, a_sel_out);
      end else begin
        e = a_q.pop_front();
        chk("a_dat", {32'd0, a_dout}, {32'd0, e.dat});
        chk("a_sel", {62'd0, a_sel_out}, {62'd0, e.sel});
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && b_vout && b_cready) begin
      if (b_q.size() == 0) begin
        total_cnt++;
        $display("FAIL b_extra_beat: got data %0h sel %0d with nothing expected", b_dout, b_sel_out);
      end else begin
        e = b_q.pop_front();
        chk("b_dat", {32'd0, b_dout}, {32'd0, e.dat});
        chk("b_sel", {62'd0, b_sel_out}, {62'd0, e.sel});
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && c_vout && c_cready) begin
      if (c_q.size() == 0) begin
        total_cnt++;
        $display("FAIL c_extra_beat: got data %0h sel %0d with nothing expected", c_dout, c_sel_out);
      end else begin
        e = c_q.pop_front();
        chk("c_dat", {32'd0, c_dout}, {32'd0, e.dat});
        chk("c_sel", {62'd0, c_sel_out}, {62'd0, e.sel});
      end
    end
  end

  int rr_seq[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_din[k*32 +: 32] = 32'hA000_0000 + k;
      b_din[k*32 +: 32] = 32'hB000_0000 + k;
    end
    for (int k = 0; k < 3; k++) c_din[k*32 +: 32] = 32'hCC00_0000 + k;
    a_vin = 4'hF; b_vin = 4'hF; c_vin = 3'b111;
    a_sel_in = 2'd0; b_sel_in = 2'd0; c_sel_in = 2'd0;
    a_cready = 1'b1; b_cready = 1'b1; c_cready = 1'b1;

    // Reset held for two edges with every channel valid
    repeat (2) begin
      tick();
      chk("rst_a_vld", {63'd0, a_vout}, 64'd0);
      chk("rst_a_dat", {32'd0, a_dout}, 64'd0);
      chk("rst_a_sel", {62'd0, a_sel_out}, 64'd0);
      chk("rst_b_vld", {63'd0, b_vout}, 64'd0);
      chk("rst_c_vld", {63'd0, c_vout}, 64'd0);
    end
    a_vin = 4'h0; b_vin = 4'h0; c_vin = 3'b000;
    rst_n = 1'b1;
    tick();

    // Fixed select, single beat on channel 2
    a_din[2*32 +: 32] = 32'hA5A5_0002;
    a_sel_in = 2'd2;
    a_vin = 4'b0100;
    #1 chk("t2_rdy", {60'd0, a_rdy}, 64'h4);
    a_q.push_back(mk(32'hA5A5_0002, 2'd2));
    tick();
    chk("t2_vld", {63'd0, a_vout}, 64'd1);

    // Stall three cycles while channel 2 data churns
    a_cready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_din[2*32 +: 32] = 32'hC0DE_0000 + i;
      #1 chk("t3_rdy_stall", {60'd0, a_rdy}, 64'd0);
      chk("t3_dat_hold", {32'd0, a_dout}, 64'hA5A5_0002);
      tick();
    end
    a_cready = 1'b1;
    a_din[2*32 +: 32] = 32'h5EED_0002;
    #1 chk("t3_rdy_resume", {60'd0, a_rdy}, 64'h4);
    a_q.push_back(mk(32'h5EED_0002, 2'd2));
    tick();
    a_vin = 4'h0;
    tick();
    chk("t3_vld_drop", {63'd0, a_vout}, 64'd0);

    // Round-robin: all valid, then only channels 1 and 3
    b_vin = 4'hF;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) b_vin = 4'b1010;
      oh = 4'b0001 << rr_seq[i];
      #1 chk("t4_rr_rdy", {60'd0, b_rdy}, {60'd0, oh});
      b_q.push_back(mk(32'hB000_0000 + rr_seq[i], 2'(rr_seq[i])));
      tick();
    end
    b_vin = 4'h0;
    tick();
    tick();

    // Out-of-range select on a 3-channel instance
    c_vin = 3'b111;
    c_sel_in = 2'd1;
    #1 chk("t5_rdy_sel1", {61'd0, c_rdy}, 64'h2);
    c_q.push_back(mk(32'hCC00_0001, 2'd1));
    tick();
    c_sel_in = 2'd3;
    #1 chk("t5_rdy_bad_sel", {61'd0, c_rdy}, 64'd0);
    chk("t5_vld_before", {63'd0, c_vout}, 64'd1);
    tick();
    chk("t5_vld_fall", {63'd0, c_vout}, 64'd0);
    chk("t5_dat_hold", {32'd0, c_dout}, 64'hCC00_0001);
    chk("t5_sel_hold", {62'd0, c_sel_out}, 64'd1);
    chk("t5_rdy_idle", {61'd0, c_rdy}, 64'd0);
    c_vin = 3'b000;
    tick();

    // Reset while stalled in round-robin mode; pointer must return to channels-1
    b_vin = 4'hF;
    #1 chk("t6_rdy_pre", {60'd0, b_rdy}, 64'h1);
    b_q.push_back(mk(32'hB000_0000, 2'd0));
    tick();
    b_cready = 1'b0;
    tick();
    chk("t6_stall_vld", {63'd0, b_vout}, 64'd1);
    chk("t6_stall_sel", {62'd0, b_sel_out}, 64'd0);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_vld", {63'd0, b_vout}, 64'd0);
    b_q.delete();
    rst_n = 1'b1;
    b_cready = 1'b1;
    #1 chk("t6_first_grant", {60'd0, b_rdy}, 64'h1);
    b_q.push_back(mk(32'hB000_0000, 2'd0));
    tick();
    b_vin = 4'h0;
    tick();
    tick();

    chk("a_q_empty", 64'(a_q.size()), 64'd0);
    chk("b_q_empty", 64'(b_q.size()), 64'd0);
    chk("c_q_empty", 64'(c_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
